// File: rtl/alu_seq.sv
// Registered ALU with valid/ready handshakes on both sides and status flags.
// Define ALU_SEQ_MULTU_EN to build the iterative shift-add MULTU unit.
module alu_seq #(
  parameter int unsigned BUS_SIZE = 32,
  parameter int unsigned SHAMT_W  = $clog2(BUS_SIZE)
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_valid,
  output logic                o_ready,
  input  logic [BUS_SIZE-1:0] i_data_1,
  input  logic [BUS_SIZE-1:0] i_data_2,
  input  logic [5:0]          i_ctrl,
  output logic                o_valid,
  input  logic                i_ready,
  output logic [BUS_SIZE-1:0] o_out,
  output logic [BUS_SIZE-1:0] o_out_hi,
  output logic                o_zero,
  output logic                o_carry,
  output logic                o_ovf
);
  localparam int unsigned MSB = BUS_SIZE - 1;

  localparam logic [5:0] OP_SLL   = 6'b000000;
  localparam logic [5:0] OP_SRL   = 6'b000010;
  localparam logic [5:0] OP_SRA   = 6'b000011;
  localparam logic [5:0] OP_MULTU = 6'b011001;
  localparam logic [5:0] OP_ADD   = 6'b100000;
  localparam logic [5:0] OP_SUB   = 6'b100010;
  localparam logic [5:0] OP_AND   = 6'b100100;
  localparam logic [5:0] OP_OR    = 6'b100101;
  localparam logic [5:0] OP_XOR   = 6'b100110;
  localparam logic [5:0] OP_NOR   = 6'b100111;
  localparam logic [5:0] OP_SLT   = 6'b101010;
  localparam logic [5:0] OP_SLTU  = 6'b101011;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MUL  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]          r_state;
  logic [1:0]          w_next;
  logic                w_accept;
  logic                w_is_mul;
  logic                w_mul_done;
  logic [SHAMT_W-1:0]  w_shamt;
  logic [BUS_SIZE:0]   w_sum;
  logic [BUS_SIZE:0]   w_diff;
  logic [BUS_SIZE-1:0] w_res;
  logic                w_carry;
  logic                w_ovf;
  logic [BUS_SIZE-1:0] r_out;
  logic                r_zero;
  logic                r_carry;
  logic                r_ovf;

  // In DONE a consumed result frees the slot on the same edge.
  assign o_ready  = i_rst_n & ((r_state == S_IDLE) | ((r_state == S_DONE) & i_ready));
  assign o_valid  = (r_state == S_DONE);
  assign w_accept = i_valid & o_ready;
  assign w_shamt  = i_data_2[SHAMT_W-1:0];
  assign w_sum    = {1'b0, i_data_1} + {1'b0, i_data_2};
  assign w_diff   = {1'b0, i_data_1} - {1'b0, i_data_2};

  assign o_out   = r_out;
  assign o_zero  = r_zero;
  assign o_carry = r_carry;
  assign o_ovf   = r_ovf;

  // Single-cycle result and flags from the operands being accepted.
  always_comb begin
    w_res   = '0;
    w_carry = 1'b0;
    w_ovf   = 1'b0;
    case (i_ctrl)
      OP_SLL:  w_res = i_data_1 << w_shamt;
      OP_SRL:  w_res = i_data_1 >> w_shamt;
      OP_SRA:  w_res = BUS_SIZE'($signed(i_data_1) >>> w_shamt);
      OP_ADD: begin
        w_res   = w_sum[MSB:0];
        w_carry = w_sum[BUS_SIZE];
        w_ovf   = (i_data_1[MSB] == i_data_2[MSB]) && (w_sum[MSB] != i_data_1[MSB]);
      end
      OP_SUB: begin
        w_res   = w_diff[MSB:0];
        w_carry = w_diff[BUS_SIZE];
        w_ovf   = (i_data_1[MSB] != i_data_2[MSB]) && (w_diff[MSB] != i_data_1[MSB]);
      end
      OP_AND:  w_res = i_data_1 & i_data_2;
      OP_OR:   w_res = i_data_1 | i_data_2;
      OP_XOR:  w_res = i_data_1 ^ i_data_2;
      OP_NOR:  w_res = ~(i_data_1 | i_data_2);
      OP_SLT:  w_res = BUS_SIZE'($signed(i_data_1) < $signed(i_data_2));
      OP_SLTU: w_res = BUS_SIZE'(i_data_1 < i_data_2);
      default: w_res = '0;
    endcase
  end

`ifdef ALU_SEQ_MULTU_EN
  logic [BUS_SIZE-1:0]   r_mcand;
  logic [BUS_SIZE-1:0]   r_acc_hi;
  logic [BUS_SIZE-1:0]   r_acc_lo;
  logic [SHAMT_W-1:0]    r_cnt;
  logic [BUS_SIZE-1:0]   r_out_hi;
  logic [BUS_SIZE:0]     w_step;
  logic [2*BUS_SIZE-1:0] w_prod;

  assign w_is_mul   = (i_ctrl == OP_MULTU);
  assign w_mul_done = (r_cnt == SHAMT_W'(BUS_SIZE - 1));
  assign w_step     = {1'b0, r_acc_hi} + (r_acc_lo[0] ? {1'b0, r_mcand} : '0);
  assign w_prod     = {w_step, r_acc_lo[MSB:1]};
  assign o_out_hi   = r_out_hi;

  // Right-shifting shift-add: low half starts as the multiplier, product emerges in {hi, lo}.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_mcand  <= '0;
      r_acc_hi <= '0;
      r_acc_lo <= '0;
      r_cnt    <= '0;
    end else if (w_accept && w_is_mul) begin
      r_mcand  <= i_data_1;
      r_acc_hi <= '0;
      r_acc_lo <= i_data_2;
      r_cnt    <= '0;
    end else if (r_state == S_MUL) begin
      {r_acc_hi, r_acc_lo} <= w_prod;
      r_cnt                <= r_cnt + SHAMT_W'(1);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_out_hi <= '0;
    end else if (w_accept && !w_is_mul) begin
      r_out_hi <= '0;
    end else if (r_state == S_MUL && w_mul_done) begin
      r_out_hi <= w_prod[2*BUS_SIZE-1:BUS_SIZE];
    end
  end
`else
  assign w_is_mul   = 1'b0;
  assign w_mul_done = 1'b1;
  assign o_out_hi   = '0;
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (w_accept)                          w_next = w_is_mul ? S_MUL : S_DONE;
        else if (r_state == S_DONE && i_ready) w_next = S_IDLE;
      end
      S_MUL:   if (w_mul_done) w_next = S_DONE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_out   <= '0;
      r_zero  <= 1'b0;
      r_carry <= 1'b0;
      r_ovf   <= 1'b0;
    end else if (w_accept && !w_is_mul) begin
      r_out   <= w_res;
      r_zero  <= (w_res == '0);
      r_carry <= w_carry;
      r_ovf   <= w_ovf;
    end
`ifdef ALU_SEQ_MULTU_EN
    else if (r_state == S_MUL && w_mul_done) begin
      r_out   <= w_prod[MSB:0];
      r_zero  <= (w_prod[MSB:0] == '0);
      r_carry <= 1'b0;
      r_ovf   <= 1'b0;
    end
`endif
  end
endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq: directed cases plus randomized ops against a
// behavioural model; MULTU expectations follow ALU_SEQ_MULTU_EN.
module tb_alu_seq;
  logic        clk;
  logic        rst_n;
  logic        i_valid;
  logic        o_ready;
  logic [31:0] i_data_1;
  logic [31:0] i_data_2;
  logic [5:0]  i_ctrl;
  logic        o_valid;
  logic        i_ready;
  logic [31:0] o_out;
  logic [31:0] o_out_hi;
  logic        o_zero;
  logic        o_carry;
  logic        o_ovf;

  int n_cmp  = 0;
  int n_fail = 0;

  typedef struct packed {
    logic [31:0] out;
    logic [31:0] hi;
    logic        zero;
    logic        carry;
    logic        ovf;
    logic [7:0]  lat;
  } exp_t;

  alu_seq #(.BUS_SIZE(32)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(i_valid), .o_ready(o_ready),
    .i_data_1(i_data_1), .i_data_2(i_data_2), .i_ctrl(i_ctrl),
    .o_valid(o_valid), .i_ready(i_ready), .o_out(o_out), .o_out_hi(o_out_hi),
    .o_zero(o_zero), .o_carry(o_carry), .o_ovf(o_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: plain integer arithmetic on the architectural definition of each op.
  function automatic exp_t model(input logic [5:0] c, input logic [31:0] a, input logic [31:0] b);
    exp_t        m;
    longint      sa;
    longint      sb;
    longint      r;
    logic [31:0] lo;
    logic [63:0] p;
    int          sh;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    sh = int'(b[4:0]);
    m = '0;
    m.lat = 8'd1;
    case (c)
      6'b000000: m.out = a << sh;
      6'b000010: m.out = a >> sh;
      6'b000011: begin r = sa >>> sh; m.out = r[31:0]; end
      6'b100000: begin
        p = 64'(a) + 64'(b); m.out = p[31:0]; m.carry = p[32];
        r = sa + sb; lo = r[31:0]; m.ovf = (r != longint'($signed(lo)));
      end
      6'b100010: begin
        m.out = a - b; m.carry = (a < b);
        r = sa - sb; lo = r[31:0]; m.ovf = (r != longint'($signed(lo)));
      end
      6'b100100: m.out = a & b;
      6'b100101: m.out = a | b;
      6'b100110: m.out = a ^ b;
      6'b100111: m.out = ~(a | b);
      6'b101010: m.out = (sa < sb) ? 32'd1 : 32'd0;
      6'b101011: m.out = (a < b) ? 32'd1 : 32'd0;
`ifdef ALU_SEQ_MULTU_EN
      6'b011001: begin p = 64'(a) * 64'(b); m.out = p[31:0]; m.hi = p[63:32]; m.lat = 8'd33; end
`endif
      default: m.out = 32'd0;
    endcase
    m.zero = (m.out == 32'd0);
    return m;
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 4))
      0:       return 32'h0000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'($urandom_range(0, 40));
      default: return 32'($urandom);
    endcase
  endfunction

  task automatic idle_cycle();
    i_valid = 1'b0;
    i_ready = 1'b1;
    @(negedge clk);
  endtask

  // Drives one op with i_ready=1; reports cycles to o_valid and whether o_ready ever rose meanwhile.
  task automatic run_op(input logic [5:0] c, input logic [31:0] a, input logic [31:0] b,
                        output int lat, output logic rdy_stayed_low);
    i_ctrl = c; i_data_1 = a; i_data_2 = b; i_valid = 1'b1; i_ready = 1'b1;
    @(negedge clk);
    i_valid = 1'b0;
    lat = 1;
    rdy_stayed_low = 1'b1;
    while (!o_valid && lat < 100) begin
      if (o_ready) rdy_stayed_low = 1'b0;
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic test_reset();
    #1;
    n_cmp++; if ({o_ready, o_valid} !== 2'b00) begin n_fail++; $display("FAIL reset_hs: ready/valid=%b want 00", {o_ready, o_valid}); end
    n_cmp++; if ({o_out, o_out_hi, o_zero, o_carry, o_ovf} !== 67'd0) begin n_fail++; $display("FAIL reset_out: out=%h hi=%h flags=%b want 0", o_out, o_out_hi, {o_zero, o_carry, o_ovf}); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++; if ({o_ready, o_valid} !== 2'b10) begin n_fail++; $display("FAIL reset_release: ready/valid=%b want 10", {o_ready, o_valid}); end
  endtask

  task automatic test_add_ovf();
    int lat; logic rl;
    idle_cycle();
    run_op(6'b100000, 32'h7FFF_FFFF, 32'h0000_0001, lat, rl);
    n_cmp++; if (lat !== 1) begin n_fail++; $display("FAIL add_lat: got %0d want 1", lat); end
    n_cmp++; if (o_out !== 32'h8000_0000) begin n_fail++; $display("FAIL add_out: got %h want 80000000", o_out); end
    n_cmp++; if ({o_ovf, o_carry, o_zero} !== 3'b100) begin n_fail++; $display("FAIL add_flags: ovf/carry/zero=%b want 100", {o_ovf, o_carry, o_zero}); end
  endtask

  task automatic test_shift_slt();
    logic [5:0]  c [4] = '{6'b000011, 6'b000010, 6'b101010, 6'b101011};
    logic [31:0] a [4] = '{32'h8000_0000, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    logic [31:0] b [4] = '{32'h24, 32'h24, 32'h1, 32'h1};
    logic [31:0] w [4] = '{32'hF800_0000, 32'h0800_0000, 32'h1, 32'h0};
    int lat; logic rl;
    for (int i = 0; i < 4; i++) begin
      run_op(c[i], a[i], b[i], lat, rl);
      n_cmp++; if (o_out !== w[i] || lat !== 1) begin n_fail++; $display("FAIL shift_slt[%0d]: out=%h lat=%0d want %h lat 1", i, o_out, lat, w[i]); end
    end
  endtask

  task automatic test_back_to_back();
    idle_cycle();
    i_ctrl = 6'b100010; i_data_1 = 32'd5; i_data_2 = 32'd5; i_valid = 1'b1; i_ready = 1'b1;
    @(negedge clk);
    n_cmp++; if ({o_valid, o_ready, o_zero, o_carry} !== 4'b1110 || o_out !== 32'd0) begin n_fail++; $display("FAIL b2b_first: v/r/z/c=%b out=%h want 1110 0", {o_valid, o_ready, o_zero, o_carry}, o_out); end
    i_data_1 = 32'd1; i_data_2 = 32'd2;
    @(negedge clk);
    n_cmp++; if ({o_valid, o_ready, o_zero, o_carry} !== 4'b1101 || o_out !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL b2b_second: v/r/z/c=%b out=%h want 1101 ffffffff", {o_valid, o_ready, o_zero, o_carry}, o_out); end
    i_valid = 1'b0;
    @(negedge clk);
    n_cmp++; if ({o_valid, o_ready} !== 2'b01) begin n_fail++; $display("FAIL b2b_drain: valid/ready=%b want 01", {o_valid, o_ready}); end
  endtask

  task automatic test_multu();
    int lat; logic rl;
    idle_cycle();
    run_op(6'b011001, 32'hFFFF_FFFF, 32'h2, lat, rl);
`ifdef ALU_SEQ_MULTU_EN
    n_cmp++; if (lat !== 33 || rl !== 1'b1) begin n_fail++; $display("FAIL multu_lat: lat=%0d ready_low=%b want 33 1", lat, rl); end
    n_cmp++; if (o_out_hi !== 32'h1 || o_out !== 32'hFFFF_FFFE) begin n_fail++; $display("FAIL multu_res: hi=%h lo=%h want 00000001 fffffffe", o_out_hi, o_out); end
`else
    n_cmp++; if (lat !== 1) begin n_fail++; $display("FAIL multu_lat: lat=%0d want 1", lat); end
    n_cmp++; if (o_out_hi !== 32'h0 || o_out !== 32'h0) begin n_fail++; $display("FAIL multu_res: hi=%h lo=%h want 0 0", o_out_hi, o_out); end
`endif
  endtask

  task automatic test_backpressure();
    idle_cycle();
    i_ctrl = 6'b100000; i_data_1 = 32'd3; i_data_2 = 32'd4; i_valid = 1'b1; i_ready = 1'b0;
    @(negedge clk);
    i_ctrl = 6'b100010; i_data_1 = 32'd9; i_data_2 = 32'd1;
    for (int i = 0; i < 5; i++) begin
      n_cmp++; if ({o_valid, o_ready} !== 2'b10 || o_out !== 32'd7) begin n_fail++; $display("FAIL bp_hold[%0d]: valid/ready=%b out=%h want 10 7", i, {o_valid, o_ready}, o_out); end
      @(negedge clk);
    end
    i_valid = 1'b0; i_ready = 1'b1;
    @(negedge clk);
    n_cmp++; if (o_valid !== 1'b0 || o_out !== 32'd7) begin n_fail++; $display("FAIL bp_release: valid=%b out=%h want 0 7", o_valid, o_out); end
  endtask

  task automatic test_reset_mid_op();
    int lat; logic rl;
    idle_cycle();
    i_ctrl = 6'b011001; i_data_1 = 32'hFFFF_FFFF; i_data_2 = 32'h2; i_valid = 1'b1; i_ready = 1'b0;
    @(negedge clk);
    i_valid = 1'b0;
    repeat (9) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if ({o_valid, o_ready} !== 2'b00 || {o_out, o_out_hi, o_zero, o_carry, o_ovf} !== 67'd0) begin n_fail++; $display("FAIL rst_mid: v/r=%b out=%h hi=%h want 00 0 0", {o_valid, o_ready}, o_out, o_out_hi); end
    @(negedge clk);
    rst_n = 1'b1; i_ready = 1'b1;
    @(negedge clk);
    n_cmp++; if ({o_valid, o_ready} !== 2'b01) begin n_fail++; $display("FAIL rst_after: valid/ready=%b want 01", {o_valid, o_ready}); end
    run_op(6'b100000, 32'd1, 32'd1, lat, rl);
    n_cmp++; if (o_out !== 32'd2 || lat !== 1) begin n_fail++; $display("FAIL rst_add: out=%h lat=%0d want 2 1", o_out, lat); end
  endtask

  task automatic test_random();
    logic [5:0] ops [14] = '{6'b000000, 6'b000010, 6'b000011, 6'b011001, 6'b100000, 6'b100010, 6'b100100,
                             6'b100101, 6'b100110, 6'b100111, 6'b101010, 6'b101011, 6'b111111, 6'b000001};
    logic [5:0]  c;
    logic [31:0] a;
    logic [31:0] b;
    exp_t        e;
    int          lat;
    logic        rl;
    for (int i = 0; i < 80; i++) begin
      c = ops[$urandom_range(0, 13)];
      a = pick();
      b = pick();
      e = model(c, a, b);
      run_op(c, a, b, lat, rl);
      n_cmp++; if (lat !== int'(e.lat)) begin n_fail++; $display("FAIL rnd_lat[%0d] op=%b: got %0d want %0d", i, c, lat, e.lat); end
      n_cmp++;
      if ({o_out, o_out_hi, o_zero, o_carry, o_ovf} !== {e.out, e.hi, e.zero, e.carry, e.ovf}) begin
        n_fail++;
        $display("FAIL rnd_res[%0d] op=%b a=%h b=%h: out=%h hi=%h zco=%b want %h %h %b",
                 i, c, a, b, o_out, o_out_hi, {o_zero, o_carry, o_ovf}, e.out, e.hi, {e.zero, e.carry, e.ovf});
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; i_valid = 1'b0; i_ready = 1'b1;
    i_ctrl = '0; i_data_1 = '0; i_data_2 = '0;
    test_reset();
    test_add_ovf();
    test_shift_slt();
    test_back_to_back();
    test_multu();
    test_backpressure();
    test_reset_mid_op();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
